dac_stream_rx: RTL and testbench
================================

# dac_stream_rx

Receive-side counterpart of the cartridge audio DAC link. It deserializes an I2S-format stream of `dac_sclk`, `dac_lrck` and `dac_sdin` into parallel 16-bit left/right samples with a valid/ack handshake. It also provides zero-frame mute detection and loss-of-clock detection. It sits beside the mapper audio outputs as an in-fabric monitor, used for mute supervision and for mapper self-test loopback.

## Interface
Parameters:
- `BITS`, 16: sample width per channel.
- `MUTE_FRAMES`, 256: consecutive all-zero frames before `mute` asserts.
- `TIMEOUT`, 4096: `clk` cycles without an SCLK rise before link loss.

Ports:
- `clk`, in, 1: system clock. Stream pins are asynchronous to it. Requires f(clk) ≥ 4×f(sclk).
- `rst`, in, 1: asynchronous, active-high reset.
- `sclk_in`, in, 1: serial bit clock from the DAC pins.
- `lrck_in`, in, 1: word select; 0 = left, 1 = right.
- `sdin_in`, in, 1: serial data, MSB first.
- `smp_l`, out, BITS: last accepted left sample.
- `smp_r`, out, BITS: last accepted right sample.
- `smp_valid`, out, 1: sample pair pending; held until acked.
- `smp_ack`, in, 1: consumer accept, sampled while `smp_valid`=1.
- `mute`, out, 1: MUTE_FRAMES zero frames seen.
- `link_up`, out, 1: stream is alive.
- `ovr_err`, out, 1: sticky; a frame was dropped while `smp_valid` was pending.
- `short_err`, out, 1: sticky; a slot ended with fewer than BITS bits.
- `err_clr`, in, 1: clears both sticky flags.

Reset values: every output is 0. Internal counters and shift registers are 0. The previous-LRCK register is 0.

## Operation
- **Pin sync:** each pin passes through 2 flip-flops. `sclk_rise` = synced sclk is 1 and its previous value was 0.
- **On each `sclk_rise`:** sample synced lrck and sdin.
  - If lrck differs from the value at the previous rise, a slot starts. Set `bitcnt` to 0 and discard this bit (I2S one-bit delay).
  - Otherwise, if `bitcnt` < BITS, shift sdin into `sh`, MSB first, and increment `bitcnt`.
  - Bits beyond BITS are ignored; `bitcnt` saturates.
- **Slot end (lrck change):**
  - If the closing slot has `bitcnt` == BITS, latch `sh` into `hold_l` or `hold_r` according to the old lrck, and set that channel's `got` flag.
  - If the closing slot has 0 < `bitcnt` < BITS, set `short_err` and clear that channel's `got`.
- **Frame complete:** the right slot reaches `bitcnt` == BITS while `got_l` is set.
  - If `smp_valid`=0, or `smp_ack`=1 in the same cycle: load `smp_l` = `hold_l`, `smp_r` = word; set `smp_valid`=1; clear `got_l`.
  - Else: drop the new frame, keep the old outputs, set `ovr_err`.
- **Ack:** `smp_ack` with `smp_valid`=1 clears `smp_valid` next cycle, unless a new frame loads in the same cycle.
- **Mute:**
  - On frame complete with both words 0: `zcnt` += 1, saturating at MUTE_FRAMES. `mute` = (`zcnt` == MUTE_FRAMES).
  - On a nonzero frame: clear `zcnt` and `mute` in that cycle.
  - Dropped frames still update mute.
- **Timeout:**
  - `idle` counts `clk` cycles and clears on each `sclk_rise`.
  - At TIMEOUT, in one cycle: `link_up` → 0, `bitcnt`, `got_*` and `sh` cleared, partial words dropped.
  - `idle` saturates. `smp_*` and `mute` are unchanged.
  - `link_up` → 1 on the next frame complete.
- **`err_clr`:** clears sticky flags. A same-cycle set wins.

## Timing
- Pin edge to `sclk_rise`: 3 `clk` (2 sync stages + edge register).
- `smp_valid` rises 1 `clk` after the `sclk_rise` carrying the 16th right bit, i.e. 4 `clk` after that pin edge.
- The ack path is single-cycle. Back-to-back frames are accepted if ack arrives before the next frame complete.
- `rst` mid-frame: all state clears immediately. The first frame after release is accepted only once a full left slot is seen.

## Structure
- Stream format constants go in the shared defs header: left polarity, one-bit delay, default BITS.
- Sub-module `dac_pin_sync`: 2-FF synchronizer with rise output. Instantiate it for sclk; lrck and sdin use its sync-only output.
- Top level contains the bit counter, slot/frame logic, handshake, mute counter and timeout counter.

## Test plan
- **Basic frame:** sclk period 8 `clk`, L=0x1234, R=0xABCD → `smp_valid` with those values, 4 `clk` after the last right-bit edge. Ack clears it next cycle.
- **Overrun:** no ack over two frames (L=1/R=2, then L=3/R=4) → outputs stay 1/2 and `ovr_err`=1. Then `err_clr` → `ovr_err`=0.
- **Simultaneous ack:** assert `smp_ack` in the frame-complete cycle → new pair loaded, `smp_valid` stays 1, `ovr_err`=0.
- **Short slot:** left slot with 10 bits → `short_err`=1 and no `smp_valid` for that frame. The next full frame is accepted.
- **Mute with MUTE_FRAMES=4:** 4 zero frames → `mute`=1 on the 4th. Then a frame with R=0x0001 → `mute`=0 in the same cycle.
- **Clock loss, TIMEOUT=64:** hold sclk=1 → `link_up`=0 at cycle 64 after the last rise. Resuming the stream → `link_up`=1 at the first complete frame.

Source files
------------

// File: rtl/dac_stream_rx_pkg.sv
// -----------------------------------------------------------------------------
// dac_stream_rx_pkg
// Stream-format constants shared by the DAC receive monitor.
//   LRCK_LEFT         : word-select level that marks the left channel slot.
//   I2S_ONE_BIT_DELAY : 1 = first bit after an LRCK change belongs to the old
//                       word (standard I2S); 0 = left-justified framing.
//   DEFAULT_BITS      : default sample width per channel.
// -----------------------------------------------------------------------------
package dac_stream_rx_pkg;

    localparam logic LRCK_LEFT         = 1'b0;
    localparam bit   I2S_ONE_BIT_DELAY = 1'b1;
    localparam int   DEFAULT_BITS      = 16;

endpackage : dac_stream_rx_pkg

// File: rtl/dac_pin_sync.sv
// -----------------------------------------------------------------------------
// dac_pin_sync
// Brings the asynchronous DAC link pins into the clk domain.
//   clk, rst   : system clock, asynchronous active-high reset.
//   sclk_in    : raw serial bit clock pin.
//   data_in    : other raw link pins (word select, data), W bits.
//   data_o     : data_in after two flip-flops.
//   rise_o     : one-cycle pulse, registered, for each rising edge of the
//                synchronised sclk (pin edge to pulse = 3 clk).
// -----------------------------------------------------------------------------
module dac_pin_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk_in,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_o,
    output logic         rise_o
);

    logic         sclk_meta_q, sclk_meta_d;
    logic         sclk_sync_q, sclk_sync_d;
    logic         sclk_prev_q, sclk_prev_d;
    logic         rise_q,      rise_d;
    logic [W-1:0] data_meta_q, data_meta_d;
    logic [W-1:0] data_sync_q, data_sync_d;

    always_comb begin
        sclk_meta_d = sclk_in;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        // Edge register: compares the synced level with its previous value.
        rise_d      = sclk_sync_q & ~sclk_prev_q;
        data_meta_d = data_in;
        data_sync_d = data_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign data_o = data_sync_q;
    assign rise_o = rise_q;

endmodule : dac_pin_sync

// File: rtl/dac_stream_rx.sv
// -----------------------------------------------------------------------------
// dac_stream_rx
// Deserialises an I2S stream (sclk/lrck/sdin) into 16-bit left/right sample
// pairs with a valid/ack handshake, plus zero-frame mute detection and
// loss-of-clock detection.
//   clk, rst        : system clock (>= 4x sclk), asynchronous active-high reset.
//   sclk_in/lrck_in/sdin_in : raw stream pins (lrck 0 = left, MSB first).
//   smp_l, smp_r    : last accepted sample pair.
//   smp_valid       : pair pending, held until smp_ack.
//   smp_ack         : consumer accept.
//   mute            : MUTE_FRAMES consecutive all-zero frames seen.
//   link_up         : stream alive (drops after TIMEOUT clk without sclk rise).
//   ovr_err         : sticky, a frame was dropped while a pair was pending.
//   short_err       : sticky, a slot closed with 0 < bits < BITS.
//   err_clr         : clears both sticky flags (a same-cycle set wins).
// -----------------------------------------------------------------------------
module dac_stream_rx
    import dac_stream_rx_pkg::*;
#(
    parameter int BITS        = DEFAULT_BITS,
    parameter int MUTE_FRAMES = 256,
    parameter int TIMEOUT     = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk_in,
    input  logic            lrck_in,
    input  logic            sdin_in,
    output logic [BITS-1:0] smp_l,
    output logic [BITS-1:0] smp_r,
    output logic            smp_valid,
    input  logic            smp_ack,
    output logic            mute,
    output logic            link_up,
    output logic            ovr_err,
    output logic            short_err,
    input  logic            err_clr
);

    localparam int CNT_W = $clog2(BITS + 1);
    localparam int ZC_W  = $clog2(MUTE_FRAMES + 1);
    localparam int IDL_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BITS_C    = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] BITS_M1_C = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ZC_W-1:0]  MUTE_C    = ZC_W'(MUTE_FRAMES);
    localparam logic [ZC_W-1:0]  ZC_ONE    = ZC_W'(1);
    localparam logic [IDL_W-1:0] TO_M1_C   = IDL_W'(TIMEOUT - 1);
    localparam logic [IDL_W-1:0] TO_C      = IDL_W'(TIMEOUT);
    localparam logic [IDL_W-1:0] IDL_ONE   = IDL_W'(1);

    logic [1:0] pins_s;
    logic       lrck_s;
    logic       sdin_s;
    logic       sclk_rise;

    dac_pin_sync #(.W(2)) u_pin_sync (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (sclk_in),
        .data_in ({lrck_in, sdin_in}),
        .data_o  (pins_s),
        .rise_o  (sclk_rise)
    );

    assign lrck_s = pins_s[1];
    assign sdin_s = pins_s[0];

    logic             lrck_prev_q, lrck_prev_d;
    logic [CNT_W-1:0] bitcnt_q,    bitcnt_d;
    logic [BITS-1:0]  sh_q,        sh_d;
    logic [BITS-1:0]  hold_l_q,    hold_l_d;
    logic             got_l_q,     got_l_d;
    logic [BITS-1:0]  smp_l_q,     smp_l_d;
    logic [BITS-1:0]  smp_r_q,     smp_r_d;
    logic             smp_valid_q, smp_valid_d;
    logic [ZC_W-1:0]  zcnt_q,      zcnt_d;
    logic             mute_q,      mute_d;
    logic [IDL_W-1:0] idle_q,      idle_d;
    logic             link_up_q,   link_up_d;
    logic             ovr_err_q,   ovr_err_d;
    logic             short_err_q, short_err_d;

    // The word as it stands once the current bit is shifted in.
    logic [BITS-1:0] word;
    assign word = {sh_q[BITS-2:0], sdin_s};

    logic frame_done;
    logic short_set;
    logic ovr_set;

    always_comb begin
        lrck_prev_d = lrck_prev_q;
        bitcnt_d    = bitcnt_q;
        sh_d        = sh_q;
        hold_l_d    = hold_l_q;
        got_l_d     = got_l_q;
        smp_l_d     = smp_l_q;
        smp_r_d     = smp_r_q;
        smp_valid_d = smp_valid_q;
        zcnt_d      = zcnt_q;
        mute_d      = mute_q;
        idle_d      = idle_q;
        link_up_d   = link_up_q;
        frame_done  = 1'b0;
        short_set   = 1'b0;
        ovr_set     = 1'b0;

        if (sclk_rise) begin
            idle_d = '0;
        end else if (idle_q != TO_C) begin
            idle_d = idle_q + IDL_ONE;
        end

        if (sclk_rise) begin
            lrck_prev_d = lrck_s;
            if (lrck_s != lrck_prev_q) begin
                // Close the previous slot before starting the new one.
                if (bitcnt_q == BITS_C) begin
                    if (lrck_prev_q == LRCK_LEFT) begin
                        hold_l_d = sh_q;
                        got_l_d  = 1'b1;
                    end
                end else if (bitcnt_q != '0) begin
                    short_set = 1'b1;
                    if (lrck_prev_q == LRCK_LEFT) begin
                        got_l_d = 1'b0;
                    end
                end
                if (I2S_ONE_BIT_DELAY) begin
                    bitcnt_d = '0;
                end else begin
                    sh_d     = word;
                    bitcnt_d = CNT_ONE;
                end
            end else if (bitcnt_q < BITS_C) begin
                sh_d     = word;
                bitcnt_d = bitcnt_q + CNT_ONE;
                if ((lrck_s != LRCK_LEFT) && (bitcnt_q == BITS_M1_C) && got_l_q) begin
                    frame_done = 1'b1;
                end
            end
        end

        if (smp_valid_q && smp_ack) begin
            smp_valid_d = 1'b0;
        end

        if (frame_done) begin
            link_up_d = 1'b1;
            if (!smp_valid_q || smp_ack) begin
                smp_l_d     = hold_l_q;
                smp_r_d     = word;
                smp_valid_d = 1'b1;
                got_l_d     = 1'b0;
            end else begin
                ovr_set = 1'b1;
            end
            // Mute tracks every completed frame, dropped or not.
            if ((hold_l_q == '0) && (word == '0)) begin
                if (zcnt_q != MUTE_C) begin
                    zcnt_d = zcnt_q + ZC_ONE;
                end
            end else begin
                zcnt_d = '0;
            end
            mute_d = (zcnt_d == MUTE_C);
        end

        // Loss of clock: fires once, in the cycle idle reaches TIMEOUT.
        if (!sclk_rise && (idle_q == TO_M1_C)) begin
            link_up_d = 1'b0;
            bitcnt_d  = '0;
            got_l_d   = 1'b0;
            sh_d      = '0;
        end

        ovr_err_d   = err_clr ? 1'b0 : ovr_err_q;
        short_err_d = err_clr ? 1'b0 : short_err_q;
        if (ovr_set) begin
            ovr_err_d = 1'b1;
        end
        if (short_set) begin
            short_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lrck_prev_q <= 1'b0;
            bitcnt_q    <= '0;
            sh_q        <= '0;
            hold_l_q    <= '0;
            got_l_q     <= 1'b0;
            smp_l_q     <= '0;
            smp_r_q     <= '0;
            smp_valid_q <= 1'b0;
            zcnt_q      <= '0;
            mute_q      <= 1'b0;
            idle_q      <= '0;
            link_up_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            lrck_prev_q <= lrck_prev_d;
            bitcnt_q    <= bitcnt_d;
            sh_q        <= sh_d;
            hold_l_q    <= hold_l_d;
            got_l_q     <= got_l_d;
            smp_l_q     <= smp_l_d;
            smp_r_q     <= smp_r_d;
            smp_valid_q <= smp_valid_d;
            zcnt_q      <= zcnt_d;
            mute_q      <= mute_d;
            idle_q      <= idle_d;
            link_up_q   <= link_up_d;
            ovr_err_q   <= ovr_err_d;
            short_err_q <= short_err_d;
        end
    end

    assign smp_l     = smp_l_q;
    assign smp_r     = smp_r_q;
    assign smp_valid = smp_valid_q;
    assign mute      = mute_q;
    assign link_up   = link_up_q;
    assign ovr_err   = ovr_err_q;
    assign short_err = short_err_q;

endmodule : dac_stream_rx

// File: tb/tb_dac_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_dac_stream_rx
// Directed bench for dac_stream_rx with BITS=16, MUTE_FRAMES=4, TIMEOUT=64.
// Each stream bit is 8 clk long (sclk low 4, high 4); every slot carries the
// one-bit-delay bit followed by its data bits, MSB first.
// -----------------------------------------------------------------------------
module tb_dac_stream_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_in = 1'b0;
    logic        lrck_in = 1'b0;
    logic        sdin_in = 1'b0;
    logic        smp_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] smp_l;
    logic [15:0] smp_r;
    logic        smp_valid;
    logic        mute;
    logic        link_up;
    logic        ovr_err;
    logic        short_err;

    int n_tests = 0;
    int n_fail  = 0;

    dac_stream_rx #(
        .BITS        (16),
        .MUTE_FRAMES (4),
        .TIMEOUT     (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .lrck_in   (lrck_in),
        .sdin_in   (sdin_in),
        .smp_l     (smp_l),
        .smp_r     (smp_r),
        .smp_valid (smp_valid),
        .smp_ack   (smp_ack),
        .mute      (mute),
        .link_up   (link_up),
        .ovr_err   (ovr_err),
        .short_err (short_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One stream bit; with open=1 it returns right after the sclk rise.
    task automatic send_bit(input logic lr, input logic b, input bit open);
        sclk_in = 1'b0;
        lrck_in = lr;
        sdin_in = b;
        wait_clks(4);
        sclk_in = 1'b1;
        if (!open) wait_clks(4);
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits, input bit open_tail);
        send_bit(lr, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(lr, w[15-i], open_tail && (i == nbits - 1));
        end
    endtask

    // Returns at the negedge where the pin rise of the 16th right bit is driven.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 16, 1'b0);
        send_slot(1'b1, r, 16, 1'b1);
    endtask

    task automatic do_ack();
        smp_ack = 1'b1;
        wait_clks(1);
        smp_ack = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        wait_clks(3);
        chk("rst_smp_l", 32'(smp_l), 32'h0);
        chk("rst_smp_r", 32'(smp_r), 32'h0);
        chk("rst_valid", 32'(smp_valid), 32'h0);
        chk("rst_mute", 32'(mute), 32'h0);
        chk("rst_link", 32'(link_up), 32'h0);
        chk("rst_ovr", 32'(ovr_err), 32'h0);
        chk("rst_short", 32'(short_err), 32'h0);
        rst = 1'b0;
        wait_clks(2);

        // Preamble: a lone right-slot start so the first real frame opens a left slot
        send_bit(1'b1, 1'b0, 1'b0);

        // Basic frame with exact latency
        send_frame(16'h1234, 16'hABCD);
        wait_clks(3);
        chk("basic_valid_early", 32'(smp_valid), 32'h0);
        wait_clks(1);
        chk("basic_valid", 32'(smp_valid), 32'h1);
        chk("basic_l", 32'(smp_l), 32'h1234);
        chk("basic_r", 32'(smp_r), 32'hABCD);
        chk("basic_link", 32'(link_up), 32'h1);
        do_ack();
        chk("basic_ack_clears", 32'(smp_valid), 32'h0);

        // Overrun: two frames, no ack
        send_frame(16'h0001, 16'h0002);
        wait_clks(4);
        chk("ovr_first_valid", 32'(smp_valid), 32'h1);
        send_frame(16'h0003, 16'h0004);
        wait_clks(4);
        chk("ovr_l_kept", 32'(smp_l), 32'h0001);
        chk("ovr_r_kept", 32'(smp_r), 32'h0002);
        chk("ovr_set", 32'(ovr_err), 32'h1);
        chk("ovr_valid_held", 32'(smp_valid), 32'h1);
        do_clr();
        chk("ovr_cleared", 32'(ovr_err), 32'h0);

        // Simultaneous ack in the frame-complete cycle
        send_frame(16'h0005, 16'h0006);
        wait_clks(3);
        smp_ack = 1'b1;
        wait_clks(1);
        smp_ack = 1'b0;
        chk("simack_valid", 32'(smp_valid), 32'h1);
        chk("simack_l", 32'(smp_l), 32'h0005);
        chk("simack_r", 32'(smp_r), 32'h0006);
        chk("simack_no_ovr", 32'(ovr_err), 32'h0);
        do_ack();
        chk("simack_ack_clears", 32'(smp_valid), 32'h0);

        // Short left slot (10 bits) then a full frame
        send_slot(1'b0, 16'hFFC0, 10, 1'b0);
        send_slot(1'b1, 16'h7777, 16, 1'b1);
        wait_clks(4);
        chk("short_set", 32'(short_err), 32'h1);
        chk("short_no_valid", 32'(smp_valid), 32'h0);
        send_frame(16'h0F0F, 16'hF0F0);
        wait_clks(4);
        chk("short_next_valid", 32'(smp_valid), 32'h1);
        chk("short_next_l", 32'(smp_l), 32'h0F0F);
        chk("short_next_r", 32'(smp_r), 32'hF0F0);
        do_ack();
        do_clr();
        chk("short_cleared", 32'(short_err), 32'h0);

        // Mute after 4 zero frames, released by a nonzero frame
        for (int k = 0; k < 3; k++) begin
            send_frame(16'h0000, 16'h0000);
            wait_clks(4);
            do_ack();
        end
        chk("mute_after3", 32'(mute), 32'h0);
        send_frame(16'h0000, 16'h0000);
        wait_clks(3);
        chk("mute_before4", 32'(mute), 32'h0);
        wait_clks(1);
        chk("mute_on4", 32'(mute), 32'h1);
        do_ack();
        send_frame(16'h0000, 16'h0001);
        wait_clks(3);
        chk("mute_held", 32'(mute), 32'h1);
        wait_clks(1);
        chk("mute_released", 32'(mute), 32'h0);
        chk("mute_rel_r", 32'(smp_r), 32'h0001);
        do_ack();

        // Clock loss: sclk held high after the last rise
        send_frame(16'h5555, 16'hAAAA);
        wait_clks(4);
        chk("to_frame_valid", 32'(smp_valid), 32'h1);
        do_ack();
        wait_clks(62);
        chk("to_link_before", 32'(link_up), 32'h1);
        wait_clks(1);
        chk("to_link_down", 32'(link_up), 32'h0);
        chk("to_smp_l_kept", 32'(smp_l), 32'h5555);
        chk("to_smp_r_kept", 32'(smp_r), 32'hAAAA);
        wait_clks(10);

        // Resume: link comes back on the first complete frame
        send_frame(16'h1111, 16'h2222);
        wait_clks(3);
        chk("resume_link_early", 32'(link_up), 32'h0);
        wait_clks(1);
        chk("resume_link_up", 32'(link_up), 32'h1);
        chk("resume_valid", 32'(smp_valid), 32'h1);
        chk("resume_l", 32'(smp_l), 32'h1111);
        chk("resume_r", 32'(smp_r), 32'h2222);
        chk("resume_no_short", 32'(short_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dac_stream_rx
